// File: rtl/md_sequencer.sv
// md_sequencer -- iterative multiply/divide sequencer feeding the HI/LO file.
//
// Runs one mult/multu/div/divu at a time as a 32-step loop: shift-add for
// multiply (multiplier LSB first) and restoring division (quotient MSB first).
// Operands are reduced to magnitudes on entry and the result signs are
// re-applied on the last step. Completion is a one-cycle over/cs pulse with
// hi/lo already stable, and pause stalls ID while HI/LO consumers must wait.
//
// Optional build macro: MD_EARLY_OUT_EN -- multiplies leave the loop as soon
// as no set multiplier bits remain (results unchanged, divide latency unchanged).
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      operation request, honoured only when idle
//   op         00 mult, 01 multu, 10 div, 11 divu
//   a, b       rs / rt operands
//   flush      abort the in-flight operation (no write-back)
//   hilo_req   ID holds an instruction that reads or writes HI/LO
//   busy       operation in flight
//   over, cs   one-cycle completion pulse / HI/LO write enable
//   hi, lo     product high/low or remainder/quotient
//   pause      ID-stage stall request
module md_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hilo_req,
  output logic        busy,
  output logic        over,
  output logic        cs,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        pause
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mdState_t;

  mdState_t state, nextState;

  logic                  isDivReg;
  logic                  prodNeg;
  logic                  quoNeg;
  logic                  remNeg;
  logic [4:0]            count;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [DATA_W-1:0]     rem;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     divisor;

  function automatic logic [DATA_W-1:0] negIf32(input logic [DATA_W-1:0] v,
                                                input logic doNeg);
    return doNeg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] negIf64(input logic [2*DATA_W-1:0] v,
                                                  input logic doNeg);
    return doNeg ? (~v + 1'b1) : v;
  endfunction

  // Operand decode and magnitudes
  logic signed [DATA_W-1:0] aSigned;
  logic signed [DATA_W-1:0] bSigned;
  logic                     opSigned;
  logic                     aNeg;
  logic                     bNeg;
  logic                     divByZero;
  logic [DATA_W-1:0]        magA;
  logic [DATA_W-1:0]        magB;
  logic                     accept;
  logic                     stepActive;

  assign aSigned   = a;
  assign bSigned   = b;
  assign opSigned  = ~op[0];
  assign aNeg      = aSigned < 0;
  assign bNeg      = bSigned < 0;
  assign divByZero = op[1] & (b == '0);
  assign magA      = negIf32(a, opSigned & aNeg);
  assign magB      = negIf32(b, opSigned & bNeg);
  assign accept    = (state == IDLE) & start & ~flush;
  assign stepActive = (state == CALC) & ~flush;

  // One loop iteration, both flavours computed in parallel
  logic [2*DATA_W-1:0] accStep;
  logic [2*DATA_W-1:0] mcandStep;
  logic [DATA_W-1:0]   mplierStep;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     trialDiff;
  logic                fits;
  logic [DATA_W-1:0]   remStep;
  logic [DATA_W-1:0]   quoStep;
  logic                lastStep;

  always_comb begin
    accStep    = acc + (mplier[0] ? mcand : '0);
    mcandStep  = {mcand[2*DATA_W-2:0], 1'b0};
    mplierStep = {1'b0, mplier[DATA_W-1:1]};

    shifted   = {rem, quo[DATA_W-1]};
    trialDiff = shifted - {1'b0, divisor};
    // With shifted[32] clear the difference is a 33-bit two's-complement
    // value whose top bit is the borrow; with it set the trial always fits.
    fits      = shifted[DATA_W] | ~trialDiff[DATA_W];
    remStep   = fits ? trialDiff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quoStep   = {quo[DATA_W-2:0], fits};

`ifdef MD_EARLY_OUT_EN
    lastStep  = (count == 5'd0) | (~isDivReg & (mplierStep == '0));
`else
    lastStep  = (count == 5'd0);
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    over      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) nextState = divByZero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (flush)         nextState = IDLE;
        else if (lastStep) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        over      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    cs    = over;
    pause = hilo_req & busy & ~over;
  end

  // Datapath: operand capture in IDLE, one step per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isDivReg <= 1'b0;
      prodNeg  <= 1'b0;
      quoNeg   <= 1'b0;
      remNeg   <= 1'b0;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept) begin
      isDivReg <= op[1];
      prodNeg  <= (op == 2'b00) & (a[DATA_W-1] ^ b[DATA_W-1]);
      quoNeg   <= (op == 2'b10) & (a[DATA_W-1] ^ b[DATA_W-1]);
      remNeg   <= (op == 2'b10) & a[DATA_W-1];
      count    <= 5'd31;
      acc      <= '0;
      mcand    <= {{DATA_W{1'b0}}, magA};
      mplier   <= magB;
      rem      <= '0;
      quo      <= magA;
      divisor  <= magB;
      if (divByZero) begin
        hi <= a;
        lo <= '1;
      end
    end else if (stepActive) begin
      count <= count - 5'd1;
      if (isDivReg) begin
        rem <= remStep;
        quo <= quoStep;
        if (lastStep) begin
          hi <= negIf32(remStep, remNeg);
          lo <= negIf32(quoStep, quoNeg);
        end
      end else begin
        acc    <= accStep;
        mcand  <= mcandStep;
        mplier <= mplierStep;
        if (lastStep) begin
          {hi, lo} <= negIf64(accStep, prodNeg);
        end
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hilo_req;
  logic        busy;
  logic        over;
  logic        cs;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        pause;

  md_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hilo_req (hilo_req),
    .busy     (busy),
    .over     (over),
    .cs       (cs),
    .hi       (hi),
    .lo       (lo),
    .pause    (pause)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          latOff;
    int          latOn;
  } vec_t;

  vec_t vecs[14];

  // Reference model: results from plain 64-bit arithmetic, latency from the
  // bit length of the multiplier magnitude.
  function automatic void refModel(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] eHi,
                                   output logic [31:0] eLo, output int eLat);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] m;
    int n;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = 64'(ux * uy);
      2'd2: p = (y == 0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: p = (y == 0) ? {x, 32'hFFFFFFFF} : {32'(ux % uy), 32'(ux / uy)};
    endcase
    eHi  = p[63:32];
    eLo  = p[31:0];
    eLat = 33;
    m    = y;
    n    = 1;
    if (o[1] && y == 0) eLat = 1;
`ifdef MD_EARLY_OUT_EN
    else if (!o[1]) begin
      if (o == 2'd0 && y[31]) m = 32'd0 - y;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      eLat = n + 1;
    end
`endif
  endfunction

  // Issue one operation and watch it to completion. lat is the number of
  // cycles from the start cycle to the first over cycle (-1 if none).
  task automatic doOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      output int lat, output logic [31:0] rHi, output logic [31:0] rLo,
                      output int pulses, output logic csOk);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = -1; pulses = 0; csOk = 1'b1; rHi = '0; rLo = '0;
    for (int c = 1; c <= 80; c++) begin
      if (cs !== over) csOk = 1'b0;
      if (over) begin
        pulses++;
        if (lat < 0) begin
          lat = c; rHi = hi; rLo = lo;
        end
      end
      if (!busy && !over) break;
      @(negedge clk);
    end
  endtask

  int          lat, eLat, pulses;
  logic [31:0] rHi, rLo, eHi, eLo;
  logic        csOk;
  logic [1:0]  rOp;
  logic [31:0] rA, rB;
  int          overSeen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 3};
    vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33, 3};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
    vecs[3]  = '{2'd3, 32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF, 1, 1};
    vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33};
    vecs[5]  = '{2'd0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 33, 4};
    vecs[6]  = '{2'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33, 33};
    vecs[7]  = '{2'd2, 32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF, 1, 1};
    vecs[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33};
    vecs[9]  = '{2'd0, 32'h12345,    32'd0,        32'h00000000, 32'h00000000, 33, 2};
    vecs[10] = '{2'd1, 32'd1,        32'd1,        32'h00000000, 32'h00000001, 33, 2};
    vecs[11] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33};
    vecs[12] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 2};
    vecs[13] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; flush = 1'b0; hilo_req = 1'b0;
    repeat (3) @(negedge clk);
    hilo_req = 1'b1;
    #1;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_over",  64'(over),  64'd0);
    check("rst_cs",    64'(cs),    64'd0);
    check("rst_pause", 64'(pause), 64'd0);
    check("rst_hi",    64'(hi),    64'd0);
    check("rst_lo",    64'(lo),    64'd0);
    hilo_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      doOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, rHi, rLo, pulses, csOk);
`ifdef MD_EARLY_OUT_EN
      eLat = vecs[i].latOn;
`else
      eLat = vecs[i].latOff;
`endif
      check($sformatf("v%0d_hi", i),     64'(rHi),    64'(vecs[i].expHi));
      check($sformatf("v%0d_lo", i),     64'(rLo),    64'(vecs[i].expLo));
      check($sformatf("v%0d_lat", i),    64'(lat),    64'(eLat));
      check($sformatf("v%0d_pulses", i), 64'(pulses), 64'd1);
      check($sformatf("v%0d_cs", i),     64'(csOk),   64'd1);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      if ($urandom_range(0, 7) == 0) rA = 32'h80000000;
      case ($urandom_range(0, 7))
        0: rB = 32'd0;
        1: rB = 32'($urandom_range(1, 20));
        2: rB = 32'hFFFFFFFF;
        default: rB = $urandom;
      endcase
      refModel(rOp, rA, rB, eHi, eLo, eLat);
      doOp(rOp, rA, rB, lat, rHi, rLo, pulses, csOk);
      check($sformatf("r%0d_hi op%0d a%h b%h", i, rOp, rA, rB), 64'(rHi), 64'(eHi));
      check($sformatf("r%0d_lo op%0d a%h b%h", i, rOp, rA, rB), 64'(rLo), 64'(eLo));
      check($sformatf("r%0d_lat", i), 64'(lat), 64'(eLat));
    end

    // pause held from start; a second start mid-operation is ignored
    @(negedge clk);
    hilo_req = 1'b1; start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = -1; pulses = 0;
    for (int c = 1; c <= 80; c++) begin
      if (over) begin
        pulses++;
        check($sformatf("pause_done_c%0d", c), 64'(pause), 64'd0);
        if (lat < 0) begin
          lat = c; rHi = hi; rLo = lo;
        end
      end else if (busy) begin
        check($sformatf("pause_busy_c%0d", c), 64'(pause), 64'd1);
      end
      if (!busy && !over) break;
      if (c == 9) begin
        start = 1'b1; op = 2'd1; a = 32'd0; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("dup_lat",    64'(lat),    64'd33);
    check("dup_hi",     64'(rHi),    64'd6);
    check("dup_lo",     64'(rLo),    64'd142);
    check("dup_pulses", 64'(pulses), 64'd1);
    check("pause_idle", 64'(pause),  64'd0);
    repeat (3) @(negedge clk);
    check("hold_hi", 64'(hi), 64'd6);
    check("hold_lo", 64'(lo), 64'd142);
    hilo_req = 1'b0;

    // flush in CALC cycle 5
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    overSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (over || cs || busy) overSeen++;
      @(negedge clk);
    end
    check("flush_no_over", 64'(overSeen), 64'd0);
    check("flush_hi", 64'(hi), 64'd6);
    check("flush_lo", 64'(lo), 64'd142);

    // start and flush together in IDLE: divide-by-zero would otherwise finish next cycle
    start = 1'b1; flush = 1'b1; op = 2'd3; a = 32'h55; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    overSeen = 0;
    for (int c = 0; c < 5; c++) begin
      if (over || cs || busy) overSeen++;
      @(negedge clk);
    end
    check("startflush_idle", 64'(overSeen), 64'd0);
    check("startflush_lo",   64'(lo),       64'd142);

    // flush during DONE leaves the completion pulse intact
    start = 1'b1; op = 2'd3; a = 32'h55; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("flushdone_over", 64'(over), 64'd1);
    check("flushdone_cs",   64'(cs),   64'd1);
    check("flushdone_hi",   64'(hi),   64'h55);
    check("flushdone_lo",   64'(lo),   64'hFFFFFFFF);
    @(negedge clk);
    flush = 1'b0;
    check("flushdone_busy", 64'(busy), 64'd0);

    // reset in the middle of CALC
    hilo_req = 1'b1;
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("midrst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy",  64'(busy),  64'd0);
    check("midrst_over",  64'(over),  64'd0);
    check("midrst_cs",    64'(cs),    64'd0);
    check("midrst_pause", 64'(pause), 64'd0);
    check("midrst_hi",    64'(hi),    64'd0);
    check("midrst_lo",    64'(lo),    64'd0);
    @(negedge clk);
    rst = 1'b0; hilo_req = 1'b0;
    overSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (over || busy) overSeen++;
      @(negedge clk);
    end
    check("midrst_no_over", 64'(overSeen), 64'd0);
    refModel(2'd0, 32'd3, 32'd5, eHi, eLo, eLat);
    doOp(2'd0, 32'd3, 32'd5, lat, rHi, rLo, pulses, csOk);
    check("postrst_hi",  64'(rHi), 64'd0);
    check("postrst_lo",  64'(rLo), 64'd15);
    check("postrst_lat", 64'(lat), 64'(eLat));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
